// File: rtl/pp_uart_baud_frac_pkg.sv
// pp_uart_baud_frac_pkg
//   Shared defaults and types for the fractional UART baud generator.
//   Defaults give 115200 baud from a 50 MHz clock with 16x oversampling:
//   50e6 / (115200 * 16) = 27.127 -> 27 + 2/16.
package pp_uart_baud_frac_pkg;

  localparam int DEF_INT_W    = 12;
  localparam int DEF_FRAC_W   = 4;
  localparam int DEF_OVS      = 16;
  localparam int DEF_RST_INT  = 27;
  localparam int DEF_RST_FRAC = 2;

  // Source of a new active divisor on an update edge.
  typedef enum logic [1:0] {
    UPD_NONE = 2'd0,
    UPD_CFG  = 2'd1,
    UPD_PEND = 2'd2
  } upd_src_e;

  // On an update opportunity a same-cycle write wins over the shadow copy,
  // because it is the newer value.
  function automatic upd_src_e upd_select(input logic cfg_wr, input logic pend_v);
    upd_src_e src;
    src = UPD_NONE;
    if (cfg_wr)      src = UPD_CFG;
    else if (pend_v) src = UPD_PEND;
    return src;
  endfunction

endpackage

// File: rtl/pp_uart_baud_frac_acc.sv
// pp_uart_baud_frac_acc
//   Fractional accumulator plus interval counter. Each oversample interval
//   is di or di+1 clk cycles, where the +1 comes from the carry of
//   acc + act_frac; ival_end marks the last cycle of an interval.
// Ports:
//   clk, rst        clock, async active-low reset
//   run             count enable; low holds counter and accumulator at 0
//   last_ival       the current interval is the last of the bit (acc restarts)
//   act_int/frac    active divisor
//   ival_end        combinational strobe, high in the final cycle of an interval
module pp_uart_baud_frac_acc #(
  parameter int INT_W  = 12,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              last_ival,
  input  logic [INT_W-1:0]  act_int,
  input  logic [FRAC_W-1:0] act_frac,
  output logic              ival_end
);

  logic [INT_W:0]    cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   sum;
  logic [INT_W-1:0]  di;
  logic [INT_W:0]    len_m1;

  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, act_frac};
    // Divisors below 2 cannot produce distinct single-cycle ticks.
    di  = (act_int < INT_W'(2)) ? INT_W'(2) : act_int;
    // acc and act only change at interval ends, so len_m1 is stable
    // throughout an interval.
    len_m1 = {1'b0, di} + {{INT_W{1'b0}}, sum[FRAC_W]} - (INT_W+1)'(1);
    ival_end = run && (cnt_q == len_m1);

    cnt_d = cnt_q + (INT_W+1)'(1);
    acc_d = acc_q;
    if (!run) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (ival_end) begin
      cnt_d = '0;
      acc_d = last_ival ? '0 : sum[FRAC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/pp_uart_baud_frac.sv
// pp_uart_baud_frac
//   Fractional-divisor UART baud generator. Produces an oversample tick,
//   a mid-bit tick and a bit-boundary tick, all registered and one cycle
//   wide. Divisor writes while running are shadowed and applied at the
//   next bit boundary so a bit is never built from two divisors.
// Ports:
//   clk, rst            clock, async active-low reset
//   soft_rst            sync active-low clear, same effect as rst
//   en                  run enable
//   cfg_wr, cfg_int,
//   cfg_frac            divisor write strobe and value
//   os_tick, mid_tick,
//   bit_tick            ticks
//   cfg_busy            a written divisor is waiting for a bit boundary
//   cfg_err             sticky: an integer divisor below 2 was loaded
module pp_uart_baud_frac
  import pp_uart_baud_frac_pkg::*;
#(
  parameter int INT_W    = DEF_INT_W,
  parameter int FRAC_W   = DEF_FRAC_W,
  parameter int OVS      = DEF_OVS,
  parameter int RST_INT  = DEF_RST_INT,
  parameter int RST_FRAC = DEF_RST_FRAC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_rst,
  input  logic              en,
  input  logic              cfg_wr,
  input  logic [INT_W-1:0]  cfg_int,
  input  logic [FRAC_W-1:0] cfg_frac,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick,
  output logic              cfg_busy,
  output logic              cfg_err
);

  localparam int OS_W = $clog2(OVS);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVS - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVS / 2 - 1);
  localparam logic [INT_W-1:0]  RST_INT_V  = INT_W'(RST_INT);
  localparam logic [FRAC_W-1:0] RST_FRAC_V = FRAC_W'(RST_FRAC);

  logic [INT_W-1:0]  act_int_q, act_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [INT_W-1:0]  pend_int_q, pend_int_d;
  logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
  logic              pend_v_q, pend_v_d;
  logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
  logic              os_tick_q, os_tick_d;
  logic              mid_tick_q, mid_tick_d;
  logic              bit_tick_q, bit_tick_d;
  logic              cfg_err_q, cfg_err_d;

  logic              run;
  logic              last_ival;
  logic              ival_end;
  logic              bit_end;
  upd_src_e          upd;
  logic [INT_W-1:0]  new_int;
  logic [FRAC_W-1:0] new_frac;

  assign run       = en && soft_rst;
  assign last_ival = (os_cnt_q == OS_LAST);

  pp_uart_baud_frac_acc #(
    .INT_W  (INT_W),
    .FRAC_W (FRAC_W)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .last_ival (last_ival),
    .act_int   (act_int_q),
    .act_frac  (act_frac_q),
    .ival_end  (ival_end)
  );

  always_comb begin
    bit_end = ival_end && last_ival;

    // Divisor changes happen only while stopped or at a bit boundary.
    upd = UPD_NONE;
    if (!en || bit_end) upd = upd_select(cfg_wr, pend_v_q);

    new_int  = (upd == UPD_CFG) ? cfg_int  : pend_int_q;
    new_frac = (upd == UPD_CFG) ? cfg_frac : pend_frac_q;

    act_int_d   = act_int_q;
    act_frac_d  = act_frac_q;
    cfg_err_d   = cfg_err_q;
    if (upd != UPD_NONE) begin
      act_int_d  = new_int;
      act_frac_d = new_frac;
      if (new_int < INT_W'(2)) cfg_err_d = 1'b1;
    end

    pend_int_d  = pend_int_q;
    pend_frac_d = pend_frac_q;
    pend_v_d    = pend_v_q;
    if (!en || bit_end) begin
      pend_v_d = 1'b0;
    end else if (cfg_wr) begin
      pend_int_d  = cfg_int;
      pend_frac_d = cfg_frac;
      pend_v_d    = 1'b1;
    end

    os_cnt_d = os_cnt_q;
    if (!en)           os_cnt_d = '0;
    else if (ival_end) os_cnt_d = os_cnt_q + OS_W'(1);  // OVS is 2^n, wraps

    os_tick_d  = ival_end;
    mid_tick_d = ival_end && (os_cnt_q == OS_MID);
    bit_tick_d = bit_end;

    if (!soft_rst) begin
      act_int_d   = RST_INT_V;
      act_frac_d  = RST_FRAC_V;
      pend_int_d  = '0;
      pend_frac_d = '0;
      pend_v_d    = 1'b0;
      os_cnt_d    = '0;
      os_tick_d   = 1'b0;
      mid_tick_d  = 1'b0;
      bit_tick_d  = 1'b0;
      cfg_err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_int_q   <= RST_INT_V;
      act_frac_q  <= RST_FRAC_V;
      pend_int_q  <= '0;
      pend_frac_q <= '0;
      pend_v_q    <= 1'b0;
      os_cnt_q    <= '0;
      os_tick_q   <= 1'b0;
      mid_tick_q  <= 1'b0;
      bit_tick_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      act_int_q   <= act_int_d;
      act_frac_q  <= act_frac_d;
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
      pend_v_q    <= pend_v_d;
      os_cnt_q    <= os_cnt_d;
      os_tick_q   <= os_tick_d;
      mid_tick_q  <= mid_tick_d;
      bit_tick_q  <= bit_tick_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign os_tick  = os_tick_q;
  assign mid_tick = mid_tick_q;
  assign bit_tick = bit_tick_q;
  assign cfg_busy = pend_v_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_pp_uart_baud_frac.sv
module tb_pp_uart_baud_frac;

  logic        clk;
  logic        rst;
  logic        soft_rst;
  logic        en;
  logic        cfg_wr;
  logic [11:0] cfg_int;
  logic [3:0]  cfg_frac;
  logic        os_tick;
  logic        mid_tick;
  logic        bit_tick;
  logic        cfg_busy;
  logic        cfg_err;

  int n_cmp = 0;
  int n_err = 0;

  pp_uart_baud_frac dut (
    .clk      (clk),
    .rst      (rst),
    .soft_rst (soft_rst),
    .en       (en),
    .cfg_wr   (cfg_wr),
    .cfg_int  (cfg_int),
    .cfg_frac (cfg_frac),
    .os_tick  (os_tick),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick),
    .cfg_busy (cfg_busy),
    .cfg_err  (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel 0: os_tick, sel 1: bit_tick. n = cycles until the tick is seen.
  task automatic wait_ev(input int sel, input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      tick();
      n++;
      if (sel == 0 ? (os_tick === 1'b1) : (bit_tick === 1'b1)) ok = 1'b1;
    end
  endtask

  task automatic write_cfg(input int i, input int f);
    cfg_wr   = 1'b1;
    cfg_int  = 12'(i);
    cfg_frac = 4'(f);
    tick();
    cfg_wr   = 1'b0;
  endtask

  task automatic check_bit(input string tag, input int exp_len);
    int n;
    bit ok;
    wait_ev(1, 2000, n, ok);
    check({tag, "_seen"}, ok, 1);
    check({tag, "_len"}, n, exp_len);
  endtask

  // One bit at the default divisor 27 + 2/16 starting with acc = 0.
  task automatic run_bit_check(input string tag);
    int n, total;
    bit ok;
    total = 0;
    for (int k = 1; k <= 16; k++) begin
      wait_ev(0, 100, n, ok);
      check($sformatf("%s_os%0d_seen", tag, k), ok, 1);
      check($sformatf("%s_os%0d_len", tag, k), n, (k == 8 || k == 16) ? 28 : 27);
      check($sformatf("%s_os%0d_mid", tag, k), mid_tick, (k == 8));
      check($sformatf("%s_os%0d_bit", tag, k), bit_tick, (k == 16));
      total += n;
    end
    check({tag, "_bit_len"}, total, 434);
  endtask

  initial begin
    int n, cnt;
    bit ok;
    rst = 1'b0; soft_rst = 1'b1; en = 1'b0; cfg_wr = 1'b0;
    cfg_int = '0; cfg_frac = '0;

    // Reset values
    #2;
    check("rst_os", os_tick, 0);
    check("rst_mid", mid_tick, 0);
    check("rst_bit", bit_tick, 0);
    check("rst_busy", cfg_busy, 0);
    check("rst_err", cfg_err, 0);
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Default divisor, 4 bits of 434
    en = 1'b1;
    run_bit_check("dflt");
    for (int b = 0; b < 3; b++) check_bit($sformatf("dflt_b%0d", b + 2), 434);

    // Write (10,0) mid-bit; applied at the next boundary
    repeat (100) tick();
    write_cfg(10, 0);
    check("wr10_busy", cfg_busy, 1);
    check_bit("wr10_cur", 333);
    check("wr10_busy_after", cfg_busy, 0);
    check_bit("wr10_next", 160);
    check("wr10_busy_next", cfg_busy, 0);

    // Two writes in one bit: the last one wins
    repeat (20) tick();
    write_cfg(10, 0);
    repeat (20) tick();
    write_cfg(20, 8);
    check("dbl_busy", cfg_busy, 1);
    check_bit("dbl_cur", 118);
    check_bit("dbl_next", 328);
    check("dbl_busy_after", cfg_busy, 0);

    // Divisor 1 clamps to 2 and sets the sticky error
    write_cfg(1, 0);
    check("clamp_busy", cfg_busy, 1);
    check("clamp_err_pre", cfg_err, 0);
    check_bit("clamp_cur", 327);
    check("clamp_err", cfg_err, 1);
    wait_ev(0, 100, n, ok);
    check("clamp_os_seen", ok, 1);
    check("clamp_os_len", n, 2);
    check_bit("clamp_rest", 30);
    write_cfg(5, 0);
    check_bit("wr5_cur", 31);
    check_bit("wr5_next", 80);
    check("wr5_err_sticky", cfg_err, 1);

    // Direct write while stopped, then restart
    en = 1'b0;
    write_cfg(27, 2);
    check("stop_wr_busy", cfg_busy, 0);
    check("stop_wr_os", os_tick, 0);
    en = 1'b1;
    run_bit_check("en_rise");

    // Drop en just before the 10th os_tick of a bit
    for (int k = 0; k < 9; k++) begin
      wait_ev(0, 100, n, ok);
      check($sformatf("pre_drop_os%0d", k + 1), ok, 1);
    end
    repeat (26) tick();
    en = 1'b0;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (os_tick !== 1'b0 || mid_tick !== 1'b0 || bit_tick !== 1'b0) cnt++;
    end
    check("drop_no_ticks", cnt, 0);
    en = 1'b1;
    run_bit_check("en_ret");
    check("en_ret_err", cfg_err, 1);

    // soft_rst with a pending write
    write_cfg(10, 0);
    check("srst_busy_pre", cfg_busy, 1);
    soft_rst = 1'b0;
    tick();
    check("srst_busy", cfg_busy, 0);
    check("srst_err", cfg_err, 0);
    check("srst_os", os_tick, 0);
    soft_rst = 1'b1;
    run_bit_check("srst");
    check_bit("srst_b2", 434);

    // Async reset between edges
    en = 1'b0;
    write_cfg(1, 0);
    check("arst_err_pre", cfg_err, 1);
    en = 1'b1;
    repeat (5) tick();
    write_cfg(10, 0);
    check("arst_busy_pre", cfg_busy, 1);
    wait_ev(0, 100, n, ok);
    check("arst_os_pre", ok, 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_os", os_tick, 0);
    check("arst_busy", cfg_busy, 0);
    check("arst_err", cfg_err, 0);
    tick();
    rst = 1'b1;
    run_bit_check("arst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
